// File: rtl/overlap_framer.sv
// Splits a continuous 64-bit PCM word stream into 50%-overlapping frames:
// each frame is the previous half-frame followed by the newest half-frame.
module overlap_framer #(
  parameter int HALF_WORDS = 4,
  parameter int CW         = $clog2(HALF_WORDS)
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        load,
  input  logic [63:0] dataIn,
  output logic        in_ready,
  input  logic        clear,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] dataOut,
  output logic        out_first,
  output logic        out_last
);

  typedef enum logic [1:0] {
    FILL     = 2'd0,
    EMIT_OLD = 2'd1,
    EMIT_NEW = 2'd2
  } state_t;

  localparam logic [CW-1:0] LAST_IDX = CW'(HALF_WORDS - 1);

  state_t        state, state_nx;
  logic [CW-1:0] wr_cnt, rd_cnt;
  logic [63:0]   old_buf [HALF_WORDS];
  logic [63:0]   new_buf [HALF_WORDS];
  logic          clear_pend;

  logic in_xfer, out_xfer, wr_last, rd_last;

  assign wr_last  = (wr_cnt == LAST_IDX);
  assign rd_last  = (rd_cnt == LAST_IDX);
  assign in_xfer  = load && in_ready;
  assign out_xfer = out_valid && out_ready;

  // Outputs decode registered state only; load/out_ready steer next state alone.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves a latch behind.
    state_nx  = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    dataOut   = '0;
    out_first = 1'b0;
    out_last  = 1'b0;
    case (state)
      FILL: begin
        in_ready = 1'b1;
        if (load && wr_last) state_nx = EMIT_OLD;
      end
      EMIT_OLD: begin
        out_valid = 1'b1;
        dataOut   = old_buf[rd_cnt];
        out_first = (rd_cnt == '0);
        if (out_ready && rd_last) state_nx = EMIT_NEW;
      end
      EMIT_NEW: begin
        out_valid = 1'b1;
        dataOut   = new_buf[rd_cnt];
        out_last  = rd_last;
        if (out_ready && rd_last) state_nx = FILL;
      end
      default: state_nx = FILL;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (!reset) begin
      state      <= FILL;
      wr_cnt     <= '0;
      rd_cnt     <= '0;
      clear_pend <= 1'b0;
      for (int i = 0; i < HALF_WORDS; i++) old_buf[i] <= '0;
    end else begin
      state <= state_nx;

      if (in_xfer) wr_cnt <= wr_last ? '0 : wr_cnt + CW'(1);
      // rd_cnt wraps to zero at both half boundaries since HALF_WORDS is 2^CW.
      if (out_xfer) rd_cnt <= rd_cnt + CW'(1);

      if (clear) begin
        if (state == FILL) begin
          for (int i = 0; i < HALF_WORDS; i++) old_buf[i] <= '0;
        end else begin
          clear_pend <= 1'b1;
        end
      end

      // End of frame: the half just emitted becomes the history half.
      if (state == EMIT_NEW && out_xfer && rd_last) begin
        for (int i = 0; i < HALF_WORDS; i++)
          old_buf[i] <= (clear_pend || clear) ? 64'h0 : new_buf[i];
        clear_pend <= 1'b0;
      end
    end
  end

  // NOTE: new_buf is deliberately unreset; it is always fully written before it is read.
  always_ff @(posedge clock) begin
    if (in_xfer) new_buf[wr_cnt] <= dataIn;
  end

endmodule
